// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencing controller.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // All-ones limit of the given width, saturating at 32 bits.
  function automatic logic [31:0] reset_limit(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/count_seq_core.sv
// Counter register with clear/increment/hold and terminal compare against limit.
module count_seq_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             at_limit
);

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (inc)   q <= q + WIDTH'(1);
  end

  assign at_limit = (q == limit);

endmodule

// File: rtl/count_seq_ctrl.sv
// Count sequencing controller: config handshake, start/pause/abort FSM, tc/done.
// Optional prescaler enabled by defining COUNT_SEQ_PRESCALE_EN.
//
// state | meaning
// IDLE  | stopped, configuration accepted
// RUN   | counting on each tick
// HOLD  | paused, count frozen
// DONE  | one-shot reached its limit, done held
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_mode,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRE_W-1:0] cfg_div,
`endif
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             tc_q;
  logic             idle_or_done;
  logic             cfg_accept;
  logic             run_step;
  logic             pre_hit;
  logic             tick;
  logic             at_limit;
  logic             restart;
  logic             core_clear;
  logic             core_inc;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign busy         = (state_q == RUN) || (state_q == HOLD);
  assign done         = (state_q == DONE);
  assign cfg_ready    = idle_or_done;
  assign cfg_accept   = cfg_valid && cfg_ready;
  assign tc           = tc_q;

  // Leaving HOLD counts on the same edge, so a pause stretches by its length.
  assign run_step = busy && !abort && !pause;
  assign tick     = run_step && pre_hit;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRE_W-1:0] div_q;
  logic [PRE_W-1:0] pre_cnt;

  assign pre_hit = (pre_cnt == div_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      pre_cnt <= '0;
    end else begin
      if (cfg_accept) div_q <= cfg_div;
      if (restart)       pre_cnt <= '0;
      else if (run_step) pre_cnt <= pre_hit ? '0 : pre_cnt + PRE_W'(1);
    end
  end
`else
  assign pre_hit = (PRE_W > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      limit_q <= WIDTH'(reset_limit(WIDTH));
      mode_q  <= MODE_PERIODIC;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tick && at_limit;
      if (cfg_accept) begin
        limit_q <= cfg_limit;
        mode_q  <= cfg_mode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      restart = 1'b1;
    end else if (start && idle_or_done) begin
      state_d = RUN;
      restart = 1'b1;
    end else if (cfg_accept && state_q == DONE) begin
      state_d = IDLE;
    end else if (busy) begin
      if (pause)                                              state_d = HOLD;
      else if (tick && at_limit && mode_q == MODE_ONESHOT)    state_d = DONE;
      else                                                    state_d = RUN;
    end
  end

  assign core_clear = restart || (tick && at_limit && mode_q == MODE_PERIODIC);
  assign core_inc   = tick && !at_limit;

  count_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (core_clear),
    .inc      (core_inc),
    .limit    (limit_q),
    .q        (q),
    .at_limit (at_limit)
  );

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a per-cycle expectation queue.
module tb_count_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_mode;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRE_W-1:0] cfg_div;
`endif
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  typedef struct {
    string tag;
    int    q;
    bit    tc;
    bit    busy;
    bit    done;
    bit    rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_limit (cfg_limit),
    .cfg_mode  (cfg_mode),
`ifdef COUNT_SEQ_PRESCALE_EN
    .cfg_div   (cfg_div),
`endif
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .q         (q),
    .tc        (tc),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    assert (act === expv) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, act, expv);
    end
  endtask

  // Queue the state expected after the next edge, clock, then pop and compare.
  task automatic cyc(input string tag, input int eq, input bit etc, input bit ebusy,
                     input bit edone, input bit erdy);
    exp_t e;
    e.tag = tag; e.q = eq; e.tc = etc; e.busy = ebusy; e.done = edone; e.rdy = erdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty got 0 expected 1", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".q"},         32'(q),   32'(e.q));
      chk({e.tag, ".tc"},        32'(tc),  32'(e.tc));
      chk({e.tag, ".busy"},      32'(busy), 32'(e.busy));
      chk({e.tag, ".done"},      32'(done), 32'(e.done));
      chk({e.tag, ".cfg_ready"}, 32'(cfg_ready), 32'(e.rdy));
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_limit = '0; cfg_mode = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
    cfg_div = '0;
`endif
    cyc("rst", 0, 0, 0, 0, 1);
    cyc("rst", 0, 0, 0, 0, 1);
    reset = 1'b0;

    // Unconfigured start: limit 15, periodic, period 16.
    start = 1'b1; cyc("dflt_start", 0, 0, 1, 0, 0); start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k < 16; k++) cyc("dflt_cnt", k, 0, 1, 0, 0);
      cyc("dflt_wrap", 0, 1, 1, 0, 0);
    end
    abort = 1'b1; cyc("dflt_abort", 0, 0, 0, 0, 1); abort = 1'b0;

    // One-shot L=5.
    cfg_valid = 1'b1; cfg_limit = 4'd5; cfg_mode = 1'b0;
    cyc("os_cfg", 0, 0, 0, 0, 1); cfg_valid = 1'b0;
    start = 1'b1; cyc("os_start", 0, 0, 1, 0, 0); start = 1'b0;
    for (int k = 1; k <= 5; k++) cyc("os_cnt", k, 0, 1, 0, 0);
    cyc("os_term", 5, 1, 0, 1, 1);
    pause = 1'b1; cyc("os_done_hold", 5, 0, 0, 1, 1); pause = 1'b0;
    cfg_valid = 1'b1; cfg_limit = 4'd3; cfg_mode = 1'b1;
    cyc("done_cfg", 5, 0, 0, 0, 1); cfg_valid = 1'b0;

    // Periodic L=3 with a 4-cycle pause at q=2.
    start = 1'b1; cyc("per_start", 0, 0, 1, 0, 0); start = 1'b0;
    for (int k = 1; k <= 3; k++) cyc("per_cnt", k, 0, 1, 0, 0);
    cyc("per_wrap", 0, 1, 1, 0, 0);
    cyc("per_cnt", 1, 0, 1, 0, 0);
    cyc("per_cnt", 2, 0, 1, 0, 0);
    pause = 1'b1;
    repeat (4) cyc("pause_hold", 2, 0, 1, 0, 0);
    pause = 1'b0;
    cyc("pause_resume", 3, 0, 1, 0, 0);
    cyc("pause_wrap", 0, 1, 1, 0, 0);

    // Abort from HOLD, then restart on the retained L=3.
    cyc("per_cnt", 1, 0, 1, 0, 0);
    cyc("per_cnt", 2, 0, 1, 0, 0);
    pause = 1'b1; cyc("hold_q2", 2, 0, 1, 0, 0);
    abort = 1'b1; cyc("hold_abort", 0, 0, 0, 0, 1);
    abort = 1'b0; pause = 1'b0;
    cyc("idle_after_abort", 0, 0, 0, 0, 1);
    start = 1'b1; cyc("restart", 0, 0, 1, 0, 0);
    cyc("start_ignored", 1, 0, 1, 0, 0); start = 1'b0;
    cyc("restart_cnt", 2, 0, 1, 0, 0);
    cyc("restart_cnt", 3, 0, 1, 0, 0);
    cyc("restart_wrap", 0, 1, 1, 0, 0);
    abort = 1'b1; cyc("abort_run", 0, 0, 0, 0, 1); abort = 1'b0;

    // L=0 periodic, configured in the start cycle.
    cfg_valid = 1'b1; cfg_limit = 4'd0; cfg_mode = 1'b1; start = 1'b1;
    cyc("l0p_start", 0, 0, 1, 0, 0); cfg_valid = 1'b0; start = 1'b0;
    repeat (5) cyc("l0p_tc", 0, 1, 1, 0, 0);
    abort = 1'b1; cyc("l0p_abort", 0, 0, 0, 0, 1); abort = 1'b0;

    // L=0 one-shot, restart from DONE, then abort beats start in DONE.
    cfg_valid = 1'b1; cfg_mode = 1'b0; start = 1'b1;
    cyc("l0o_start", 0, 0, 1, 0, 0); cfg_valid = 1'b0; start = 1'b0;
    cyc("l0o_done", 0, 1, 0, 1, 1);
    start = 1'b1; cyc("l0o_restart", 0, 0, 1, 0, 0); start = 1'b0;
    cyc("l0o_done2", 0, 1, 0, 1, 1);
    abort = 1'b1; start = 1'b1; cyc("done_abort", 0, 0, 0, 0, 1);
    abort = 1'b0; start = 1'b0;

`ifdef COUNT_SEQ_PRESCALE_EN
    // Divide by 3 with L=2: q steps every 3 cycles, tc period 9.
    cfg_valid = 1'b1; cfg_limit = 4'd2; cfg_mode = 1'b1; cfg_div = 4'd2;
    cyc("ps_cfg", 0, 0, 0, 0, 1); cfg_valid = 1'b0;
    start = 1'b1; cyc("ps_start", 0, 0, 1, 0, 0); start = 1'b0;
    repeat (2) cyc("ps_q0", 0, 0, 1, 0, 0);
    for (int p = 0; p < 2; p++) begin
      repeat (3) cyc("ps_q1", 1, 0, 1, 0, 0);
      repeat (3) cyc("ps_q2", 2, 0, 1, 0, 0);
      cyc("ps_wrap", 0, 1, 1, 0, 0);
      repeat (2) cyc("ps_q0", 0, 0, 1, 0, 0);
    end
    abort = 1'b1; cyc("ps_abort", 0, 0, 0, 0, 1); abort = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
